prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that writes the instruction memory read by the IF stage. It receives a byte-serial program image over a valid/ready stream and writes 16-bit words into sequential instruction-memory addresses. It holds the pipeline (`cpu_hold`) until a complete image with a correct checksum has been written. It sits beside the processor top, driving the instruction memory's write port while the processor only reads it.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0000: instruction-memory word address of the first loaded word.
- `MAX_WORDS`, 1024: largest accepted word count. A larger header count is an error.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse that begins a load; honored only in IDLE, DONE or ERROR.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  16  word address for the write.
- `imem_wdata`  out  16  word to write.
- `cpu_hold`  out  1  high keeps the pipeline stalled; low only in DONE.
- `done`  out  1  level; image loaded and checksum matched.
- `error`  out  1  level; checksum mismatch or oversize count.

## Operation
- A byte is accepted on a rising edge where `byte_valid && byte_ready`.
- Frame format, in this order:
  - LEN_HI and LEN_LO: word count N, high byte first.
  - N words of two bytes each, high byte first.
  - One checksum byte equal to the XOR of every preceding frame byte (both length bytes and all data bytes).
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- State transitions:
  - IDLE → LEN_HI on `start`.
  - LEN_HI → LEN_LO on an accepted byte.
  - LEN_LO, on an accepted byte:
    - N > MAX_WORDS → ERROR.
    - N == 0 → CHECK.
    - Otherwise → DATA_HI.
  - DATA_HI → DATA_LO on an accepted byte.
  - DATA_LO, on an accepted byte: → DATA_HI if words remain, else → CHECK.
  - CHECK, on an accepted byte: → DONE if the running XOR equals the byte, else → ERROR.
  - DONE or ERROR → LEN_HI on `start`.
- `start` in any other state is ignored.
- Internal registers:
  - 16-bit remaining-word counter, loaded from N.
  - 16-bit write index, cleared on entry to LEN_HI.
  - 8-bit running XOR, cleared on entry to LEN_HI.
  - 8-bit high-byte holding register.
- Each accepted DATA_LO byte produces a write the following cycle:
  - `imem_we` = 1.
  - `imem_addr` = BASE_ADDR + index, computed mod 2^16 (wraps silently).
  - `imem_wdata` = {held high byte, low byte}.
  - The index increments after the write.
- `byte_ready` = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 in IDLE, DONE and ERROR.
- Output levels by state:
  - `cpu_hold` = 0 only in DONE.
  - `done` = 1 only in DONE.
  - `error` = 1 only in ERROR.
- Restarting with `start` from DONE raises `cpu_hold` in the next cycle and clears `done`. Restarting from ERROR clears `error`.

## Timing
- Reset values: state IDLE, `cpu_hold`=1, `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `error`=0, all counters 0. Reset takes effect immediately, including mid-load. No partial write completes after reset is asserted.
- Throughput: one byte per cycle, with no bubbles. Back-to-back words produce `imem_we` every second cycle.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered and valid the cycle after the DATA_LO byte is accepted. They are held at their last values when `imem_we`=0.
- Status latency: `done`/`error` assert, and `cpu_hold` falls, the cycle after the checksum byte is accepted. On an oversize count, `error` asserts the cycle after LEN_LO is accepted.
- The final word's `imem_we` fires in the same cycle the loader is in CHECK, so all writes precede `done`.
- `byte_valid` may drop at any time. A stalled stream holds all state indefinitely.

## Test plan
- **Basic load.** Reset; `start`; stream 00 02 12 34 AB CD, checksum 00^02^12^34^AB^CD=0x42. Expect writes (0000,1234) and (0001,ABCD), then `done`=1 and `cpu_hold`=0 one cycle after the 0x42 byte.
- **Bad checksum.** Same stream with checksum 0x43. Expect both writes to occur, then `error`=1, `cpu_hold`=1, `done`=0 and `byte_ready`=0.
- **Empty and oversize counts.** Length 00 00 with checksum 00 → `done`, no writes. Length 04 01 (1025) → `error` one cycle after LEN_LO, no writes, and no further bytes accepted.
- **Gapped stream.** Basic load with `byte_valid` randomly deasserted 50% of cycles. Expect identical writes and `done`. `imem_we` must never pulse while stalled.
- **Reset mid-load and restart.** Assert `rst_n`=0 after 3 data bytes. Expect all outputs at reset values immediately and no write of the partial word. Then `start` plus a full image → `done`. Then `start` from DONE → `cpu_hold`=1 the next cycle.
- **Parameter wrap.** With BASE_ADDR=16'hFFFF, a 2-word load writes addresses FFFF then 0000.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready; the source may drop byte_valid at any time.
interface prog_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;

    // master: stream source plus memory observer; slave: the loader itself
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length/data/checksum byte frame, writes 16-bit
// words into instruction memory and holds the CPU until a verified image is in place.
module prog_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [2:0]    o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_remain;
    logic [15:0] r_index;
    logic [7:0]  r_xor;
    logic [7:0]  r_hi;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic        w_ready;
    logic        w_accept;
    logic        w_restart;
    logic [15:0] w_len;

    assign w_ready   = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                       (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                       (r_state == S_CHECK);
    assign w_accept  = bus.byte_valid && w_ready;
    assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERROR));
    // Length high byte is parked in the same holding register used for data high bytes.
    assign w_len     = {r_hi, bus.byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_restart) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if ({1'b0, w_len} > MAX_N) w_next = S_ERROR;
                    else if (w_len == 16'd0)   w_next = S_CHECK;
                    else                       w_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (w_accept) w_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (w_accept) w_next = (r_remain != 16'd1) ? S_DATA_HI : S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) w_next = (r_xor == bus.byte_data) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (w_restart) w_next = S_LEN_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remain <= 16'd0;
            r_index  <= 16'd0;
            r_xor    <= 8'd0;
            r_hi     <= 8'd0;
            r_we     <= 1'b0;
            r_addr   <= 16'd0;
            r_wdata  <= 16'd0;
        end else begin
            r_we <= 1'b0;
            if (w_restart) begin
                r_index  <= 16'd0;
                r_xor    <= 8'd0;
                r_remain <= 16'd0;
            end
            if (w_accept) begin
                // The checksum byte itself is compared, not folded in.
                if (r_state != S_CHECK) r_xor <= r_xor ^ bus.byte_data;
                unique case (r_state)
                    S_LEN_HI:  r_hi <= bus.byte_data;
                    S_LEN_LO:  r_remain <= w_len;
                    S_DATA_HI: r_hi <= bus.byte_data;
                    S_DATA_LO: begin
                        r_we     <= 1'b1;
                        r_addr   <= BASE_ADDR + r_index;
                        r_wdata  <= {r_hi, bus.byte_data};
                        r_index  <= r_index + 16'd1;
                        r_remain <= r_remain - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign cpu_hold       = (r_state != S_DONE);
    assign done           = (r_state == S_DONE);
    assign error          = (r_state == S_ERROR);
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0000 and FFFF) fed the same byte stream,
// with expected writes and status derived from the frame contents.
module tb_prog_loader;
    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        cpu_hold0, done0, error0;
    logic        cpu_hold1, done1, error1;
    logic [2:0]  st0, st1;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [15:0] words_q[$];

    prog_loader_if bus0();
    prog_loader_if bus1();

    assign bus0.byte_valid = byte_valid;
    assign bus0.byte_data  = byte_data;
    assign bus1.byte_valid = byte_valid;
    assign bus1.byte_data  = byte_data;

    prog_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(MAXW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
        .cpu_hold(cpu_hold0), .done(done0), .error(error0), .o_dbg_state(st0)
    );

    prog_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(MAXW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
        .cpu_hold(cpu_hold1), .done(done1), .error(error1), .o_dbg_state(st1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: every write strobe must match the next expected write ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && bus0.imem_we) begin
            if (exp_q0.size() != 0) e = exp_q0.pop_front();
            else                    e = 32'hDEAD_BEEF;
            chk("wr0", {bus0.imem_addr, bus0.imem_wdata}, e);
        end
        if (rst_n && bus1.imem_we) begin
            if (exp_q1.size() != 0) e = exp_q1.pop_front();
            else                    e = 32'hDEAD_BEEF;
            chk("wr1", {bus1.imem_addr, bus1.imem_wdata}, e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int n;
        n = 0;
        while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!bus0.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", n, 0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err, input bit exp_rdy);
        chk({tag, "_done0"},  done0,  exp_done);
        chk({tag, "_err0"},   error0, exp_err);
        chk({tag, "_hold0"},  cpu_hold0, !exp_done);
        chk({tag, "_rdy0"},   bus0.byte_ready, exp_rdy);
        chk({tag, "_done1"},  done1,  exp_done);
        chk({tag, "_err1"},   error1, exp_err);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"},    {bus0.imem_we, bus1.imem_we}, 2'b00);
        chk({tag, "_addr"},  bus0.imem_addr, 16'h0000);
        chk({tag, "_wdata"}, bus0.imem_wdata, 16'h0000);
        chk({tag, "_addr1"}, bus1.imem_addr, 16'h0000);
        chk({tag, "_rdy"},   {bus0.byte_ready, bus1.byte_ready}, 2'b00);
        chk({tag, "_hold"},  {cpu_hold0, cpu_hold1}, 2'b11);
        chk({tag, "_stat"},  {done0, error0, done1, error1}, 4'b0000);
    endtask

    // Reference model: build the frame, predict writes and outcome, then stream it.
    task automatic run_load(input string tag, input int n, input bit bad_ck, input int gap);
        logic [7:0]  fr[$];
        logic [7:0]  ck;
        logic [15:0] nl;
        logic [15:0] a1;
        bit          ok;
        nl = 16'(n);
        fr.push_back(nl[15:8]);
        fr.push_back(nl[7:0]);
        if (n <= MAXW) begin
            for (int i = 0; i < n; i++) begin
                fr.push_back(words_q[i][15:8]);
                fr.push_back(words_q[i][7:0]);
                a1 = 16'hFFFF + 16'(i);
                exp_q0.push_back({16'(i), words_q[i]});
                exp_q1.push_back({a1, words_q[i]});
            end
            ck = 8'h00;
            foreach (fr[i]) ck = ck ^ fr[i];
            if (bad_ck) ck = ck ^ 8'h01;
            fr.push_back(ck);
        end
        ok = (n <= MAXW) && !bad_ck;
        pulse_start();
        foreach (fr[i]) send_byte(fr[i], gap);
        check_status(tag, ok, !ok, 1'b0);
        chk({tag, "_wq0_left"}, exp_q0.size(), 0);
        chk({tag, "_wq1_left"}, exp_q1.size(), 0);
    endtask

    task automatic set_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int n;
        bit bad;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        @(negedge clk);
        chk("idle_rdy", bus0.byte_ready, 1'b0);
        byte_valid = 1'b0;

        // Basic load; second instance covers the FFFF -> 0000 address wrap
        words_q = '{16'h1234, 16'hABCD};
        run_load("basic", 2, 1'b0, 0);

        run_load("badck", 2, 1'b1, 0);
        run_load("empty", 0, 1'b0, 0);

        run_load("oversize", 1025, 1'b0, 0);
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("oversize_noacc", {bus0.byte_ready, error0}, 2'b01);
        end
        byte_valid = 1'b0;

        words_q = '{16'h1234, 16'hABCD};
        run_load("gapped", 2, 1'b0, 50);

        for (int k = 0; k < 6; k++) begin
            n   = $urandom_range(8, 1);
            bad = ($urandom_range(3, 0) == 0);
            set_words(n);
            run_load("rand", n, bad, $urandom_range(60, 0));
        end

        set_words(MAXW);
        run_load("maxw", MAXW, 1'b0, 0);

        // Reset after three data bytes: only the completed first word may be written
        pulse_start();
        exp_q0.push_back({16'h0000, 16'h1234});
        exp_q1.push_back({16'hFFFF, 16'h1234});
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        chk("midrst_wq0", exp_q0.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) @(negedge clk);
        check_reset("midrst_hold");
        rst_n = 1'b1;

        words_q = '{16'h1234, 16'hABCD};
        run_load("after_rst", 2, 1'b0, 0);

        pulse_start();
        check_status("restart", 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
